// File: rtl/port_display_scheduler_if.sv
// Signal bundle between the processor output ports, the two raw buttons
// and the LED page display.
interface port_display_scheduler_if #(
   parameter int WIDTH = 32
);
   // No handshake: every input is free-running and sampled on every rising
   // clock edge; led, page and auto_mode are registered outputs.
   logic [WIDTH-1:0] PORT_A;
   logic [WIDTH-1:0] PORT_B;
   logic [WIDTH-1:0] PORT_C;
   logic [WIDTH-1:0] PORT_D;
   logic             btn_next;
   logic             btn_mode;
   logic [15:0]      led;
   logic [2:0]       page;
   logic             auto_mode;

   modport master (
      output PORT_A, PORT_B, PORT_C, PORT_D, btn_next, btn_mode,
      input  led, page, auto_mode
   );

   modport slave (
      input  PORT_A, PORT_B, PORT_C, PORT_D, btn_next, btn_mode,
      output led, page, auto_mode
   );
endinterface

// File: rtl/port_display_scheduler.sv
// Time-shares the 16-bit LED bank across eight half-word pages of the four
// processor output ports, stepped by a dwell timer or a debounced button.
module port_display_scheduler_button #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         count   <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         // Any cycle agreeing with the accepted level restarts qualification.
         if (sync2 == level) begin
            count <= '0;
         end else if (count == COUNT_LAST) begin
            level <= sync2;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign press = level & ~level_q;
endmodule

module port_display_scheduler #(
   parameter int WIDTH           = 32,
   parameter int DWELL_CYCLES    = 100_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   port_display_scheduler_if.slave bus
);
   localparam int DW = $clog2(DWELL_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   typedef enum logic {
      AUTO   = 1'b0,
      MANUAL = 1'b1
   } mode_t;

   mode_t            state;
   mode_t            state_next;
   logic [DW-1:0]    dwell;
   logic [DW-1:0]    dwell_next;
   logic [2:0]       page;
   logic [2:0]       page_next;
   logic [15:0]      led;
   logic [WIDTH-1:0] sel_port;
   logic             next_press;
   logic             mode_press;
   logic             dwell_wrap;

   port_display_scheduler_button #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_next (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_next),
      .press (next_press)
   );

   port_display_scheduler_button #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_mode (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.btn_mode),
      .press (mode_press)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= AUTO;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      page_next  = page;
      dwell_next = dwell;
      dwell_wrap = (state == AUTO) && (dwell == DWELL_LAST);
      if (mode_press) begin
         state_next = (state == AUTO) ? MANUAL : AUTO;
      end
      // A press coinciding with expiry still advances by exactly one page.
      if (next_press || dwell_wrap) begin
         page_next = page + 3'd1;
      end
      if (state == MANUAL || mode_press || next_press || dwell_wrap) begin
         dwell_next = '0;
      end else begin
         dwell_next = dwell + 1'b1;
      end
   end

   always_comb begin
      sel_port = bus.PORT_A;
      case (page[2:1])
         2'd0:    sel_port = bus.PORT_A;
         2'd1:    sel_port = bus.PORT_B;
         2'd2:    sel_port = bus.PORT_C;
         default: sel_port = bus.PORT_D;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dwell <= '0;
         page  <= '0;
         led   <= '0;
      end else begin
         dwell <= dwell_next;
         page  <= page_next;
         led   <= page[0] ? sel_port[31:16] : sel_port[15:0];
      end
   end

   assign bus.led       = led;
   assign bus.page      = page;
   assign bus.auto_mode = (state == AUTO);
endmodule

// File: tb/tb_port_display_scheduler.sv
// Bench for port_display_scheduler: directed tables and corner sequences plus
// randomized traffic checked against a window-based reference model.
module tb_port_display_scheduler;
   localparam int DWELL = 8;
   localparam int DEB   = 4;
   localparam logic [31:0] PA = 32'hAAAA_1111;
   localparam logic [31:0] PB = 32'hBBBB_2222;
   localparam logic [31:0] PC = 32'hCCCC_3333;
   localparam logic [31:0] PD = 32'hDDDD_4444;

   typedef struct packed {
      logic [2:0]            page;
      logic                  auto_m;
      logic [15:0]           led;
      logic [31:0]           last_clear;
      logic [1:0]            s1;
      logic [1:0]            s2;
      logic [1:0]            deb;
      logic [1:0]            rose;
      logic [1:0][DEB-1:0]   hist;
   } model_t;

   typedef struct {
      int          edge_n;
      logic [2:0]  page;
      logic [15:0] led;
   } auto_vec_t;

   typedef struct {
      int hold;
      int delta;
   } pulse_vec_t;

   logic        clk;
   logic        reset;
   int          errors;
   int          checks;
   int          exp_page;
   int          cur;
   logic [31:0] cyc;
   model_t      m;
   logic [19:0] exp_q[$];
   auto_vec_t   auto_tab[14];
   pulse_vec_t  pulse_tab[5];

   port_display_scheduler_if #(.WIDTH(32)) bus ();

   port_display_scheduler #(
      .WIDTH           (32),
      .DWELL_CYCLES    (DWELL),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] half_of(input logic [2:0] p, input logic [3:0][31:0] pv);
      logic [31:0] word;
      word = pv[p / 3'd2];
      return (p % 3'd2 == 3'd1) ? word[31:16] : word[15:0];
   endfunction

   // One clock edge of the reference: a button level is accepted once the
   // synchronized input has disagreed with it for DEB consecutive edges.
   function automatic model_t model_step(input model_t s, input logic rst, input logic [1:0] raw,
                                         input logic [3:0][31:0] pv, input logic [31:0] now);
      model_t       n;
      logic [DEB-1:0] h;
      n = s;
      if (rst) begin
         n            = '0;
         n.auto_m     = 1'b1;
         n.last_clear = now;
         return n;
      end
      n.led = half_of(s.page, pv);
      if (s.rose[1]) begin
         n.auto_m     = ~s.auto_m;
         n.last_clear = now;
      end
      if (s.rose[0]) begin
         n.page       = s.page + 3'd1;
         n.last_clear = now;
      end else if (s.auto_m && (now - s.last_clear == DWELL)) begin
         n.page       = s.page + 3'd1;
         n.last_clear = now;
      end
      for (int b = 0; b < 2; b++) begin
         h          = {s.hist[b][DEB-2:0], s.s2[b]};
         n.hist[b]  = h;
         n.s2[b]    = s.s1[b];
         n.s1[b]    = raw[b];
         n.deb[b]   = (h == {DEB{~s.deb[b]}}) ? ~s.deb[b] : s.deb[b];
         n.rose[b]  = n.deb[b] & ~s.deb[b];
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wait_edges(2);
      reset = 1'b0;
   endtask

   task automatic press_next(input int hold);
      bus.btn_next = 1'b1;
      wait_edges(hold);
      bus.btn_next = 1'b0;
      wait_edges(12);
   endtask

   // Reference model runs on every rising edge and queues its expected outputs.
   initial begin
      m   = '0;
      cyc = '0;
      forever begin
         @(posedge clk);
         m = model_step(m, reset, {bus.btn_mode, bus.btn_next},
                        {bus.PORT_D, bus.PORT_C, bus.PORT_B, bus.PORT_A}, cyc);
         cyc = cyc + 1;
         exp_q.push_back({m.page, m.auto_m, m.led});
      end
   end

   // Scoreboard: compare DUT outputs against the queued expectations mid-cycle.
   initial begin
      logic [19:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_page", {29'd0, bus.page}, {29'd0, e[19:17]});
            check("sb_auto", {31'd0, bus.auto_mode}, {31'd0, e[16]});
            check("sb_led", {16'd0, bus.led}, {16'd0, e[15:0]});
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      auto_tab = '{
         '{1,  3'd0, 16'h1111}, '{7,  3'd0, 16'h1111}, '{8,  3'd1, 16'h1111},
         '{9,  3'd1, 16'hAAAA}, '{16, 3'd2, 16'hAAAA}, '{17, 3'd2, 16'h2222},
         '{25, 3'd3, 16'hBBBB}, '{33, 3'd4, 16'h3333}, '{41, 3'd5, 16'hCCCC},
         '{49, 3'd6, 16'h4444}, '{56, 3'd7, 16'h4444}, '{57, 3'd7, 16'hDDDD},
         '{64, 3'd0, 16'hDDDD}, '{65, 3'd0, 16'h1111}
      };
      pulse_tab = '{'{1, 0}, '{2, 0}, '{3, 0}, '{4, 1}, '{10, 1}};

      reset        = 1'b1;
      bus.PORT_A   = PA;
      bus.PORT_B   = PB;
      bus.PORT_C   = PC;
      bus.PORT_D   = PD;
      bus.btn_next = 1'b0;
      bus.btn_mode = 1'b0;

      wait_edges(2);
      check("rst_led", {16'd0, bus.led}, 32'd0);
      check("rst_page", {29'd0, bus.page}, 32'd0);
      check("rst_auto", {31'd0, bus.auto_mode}, 32'd1);
      reset = 1'b0;

      cur = 0;
      for (int i = 0; i < 14; i++) begin
         wait_edges(auto_tab[i].edge_n - cur);
         cur = auto_tab[i].edge_n;
         check($sformatf("auto_page[%0d]", i), {29'd0, bus.page}, {29'd0, auto_tab[i].page});
         check($sformatf("auto_led[%0d]", i), {16'd0, bus.led}, {16'd0, auto_tab[i].led});
      end

      // Enter MANUAL: mode press with e0 on the first edge after reset.
      do_reset();
      bus.btn_mode = 1'b1;
      wait_edges(6);
      check("mode_before", {31'd0, bus.auto_mode}, 32'd1);
      wait_edges(1);
      check("mode_after", {31'd0, bus.auto_mode}, 32'd0);
      check("mode_page", {29'd0, bus.page}, 32'd0);
      wait_edges(3);
      bus.btn_mode = 1'b0;
      wait_edges(8);
      exp_page = 0;
      for (int i = 0; i < 9; i++) begin
         bus.btn_next = 1'b1;
         wait_edges(6);
         check($sformatf("man_hold[%0d]", i), {29'd0, bus.page}, exp_page);
         wait_edges(1);
         exp_page = (exp_page + 1) % 8;
         check($sformatf("man_step[%0d]", i), {29'd0, bus.page}, exp_page);
         wait_edges(3);
         bus.btn_next = 1'b0;
         wait_edges(8);
      end
      check("man_wrap", {29'd0, bus.page}, 32'd1);

      for (int i = 0; i < 5; i++) begin
         press_next(pulse_tab[i].hold);
         exp_page = (exp_page + pulse_tab[i].delta) % 8;
         check($sformatf("pulse_hold%0d", pulse_tab[i].hold), {29'd0, bus.page}, exp_page);
      end

      // Release bounce after a valid press.
      bus.btn_next = 1'b1; wait_edges(10);
      bus.btn_next = 1'b0; wait_edges(2);
      bus.btn_next = 1'b1; wait_edges(2);
      bus.btn_next = 1'b0; wait_edges(1);
      bus.btn_next = 1'b1; wait_edges(1);
      bus.btn_next = 1'b0; wait_edges(12);
      exp_page = (exp_page + 1) % 8;
      check("bounce_page", {29'd0, bus.page}, exp_page);
      check("bounce_auto", {31'd0, bus.auto_mode}, 32'd0);

      // Next press lands on the same edge as dwell expiry (edge 8).
      do_reset();
      wait_edges(1);
      bus.btn_next = 1'b1;
      wait_edges(6);
      check("sim_pre", {29'd0, bus.page}, 32'd0);
      wait_edges(1);
      check("sim_edge8", {29'd0, bus.page}, 32'd1);
      wait_edges(3);
      bus.btn_next = 1'b0;
      wait_edges(4);
      check("sim_edge15", {29'd0, bus.page}, 32'd1);
      wait_edges(1);
      check("sim_edge16", {29'd0, bus.page}, 32'd2);

      // Both buttons together.
      do_reset();
      bus.btn_next = 1'b1;
      bus.btn_mode = 1'b1;
      wait_edges(6);
      check("both_pre_page", {29'd0, bus.page}, 32'd0);
      wait_edges(1);
      check("both_page", {29'd0, bus.page}, 32'd1);
      check("both_auto", {31'd0, bus.auto_mode}, 32'd0);
      wait_edges(3);
      bus.btn_next = 1'b0;
      bus.btn_mode = 1'b0;
      wait_edges(10);
      check("both_hold", {29'd0, bus.page}, 32'd1);

      // Reset mid-operation with a debounce count in flight.
      for (int i = 0; i < 4; i++) press_next(10);
      check("mid_page5", {29'd0, bus.page}, 32'd5);
      bus.btn_next = 1'b1;
      wait_edges(3);
      reset = 1'b1;
      wait_edges(1);
      check("mid_rst_page", {29'd0, bus.page}, 32'd0);
      check("mid_rst_led", {16'd0, bus.led}, 32'd0);
      check("mid_rst_auto", {31'd0, bus.auto_mode}, 32'd1);
      wait_edges(1);
      reset = 1'b0;
      wait_edges(1);
      check("held_led", {16'd0, bus.led}, 32'h1111);
      wait_edges(5);
      check("held_pre", {29'd0, bus.page}, 32'd0);
      wait_edges(1);
      check("held_step", {29'd0, bus.page}, 32'd1);
      bus.btn_next = 1'b0;
      wait_edges(10);

      // Randomized traffic, checked only by the scoreboard.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) bus.btn_next = ~bus.btn_next;
         if ($urandom_range(0, 29) == 0) bus.btn_mode = ~bus.btn_mode;
         if ($urandom_range(0, 7) == 0) bus.PORT_A = $urandom;
         if ($urandom_range(0, 7) == 0) bus.PORT_B = $urandom;
         if ($urandom_range(0, 7) == 0) bus.PORT_C = $urandom;
         if ($urandom_range(0, 7) == 0) bus.PORT_D = $urandom;
         reset = ($urandom_range(0, 399) == 0);
         wait_edges(1);
      end
      reset = 1'b0;
      wait_edges(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
